shufflenet_layer_pipe: RTL and testbench

//  Parametrised N-channel ShuffleNet layer datapath with valid/ready streaming. Per window it

---
 rtl/shufflenet_pkg.sv | 45 ++++
 rtl/shufflenet_layer_pipe_if.sv | 25 ++
 rtl/fixed_sat_relu6.sv | 36 +++
 rtl/shufflenet_layer_pipe.sv | 183 ++++++++++++++++++
 tb/tb_shufflenet_layer_pipe.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shufflenet_pkg.sv
// Shared types, fixed-point constants and helpers for the ShuffleNet layer datapath.
package shufflenet_pkg;

  typedef enum logic [1:0] {
    ModeDwconv  = 2'b00,
    ModeMaxpool = 2'b01,
    ModeAdd     = 2'b10,
    ModePass    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StPost,
    StOut
  } state_e;

  localparam int unsigned FRAC_W_DEF = 8;
  localparam int          ONE        = 1 << FRAC_W_DEF;
  localparam int          SIX        = 6 * ONE;

  // Output channel that input channel c lands on after a g-group shuffle.
  function automatic int unsigned shuffle_idx(input int unsigned c, input int unsigned n_ch,
                                              input int unsigned groups);
    int unsigned k;
    k = n_ch / groups;
    return (c % k) * groups + c / k;
  endfunction

  function automatic logic signed [63:0] six_of(input int unsigned frac_w);
    return 64'sd6 <<< frac_w;
  endfunction

  // Clamp a wide signed value to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/shufflenet_layer_pipe_if.sv
// Tap input stream and result output stream of the layer datapath.
interface shufflenet_layer_pipe_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 16
);
  logic                     tap_valid;
  logic                     tap_ready;
  logic [N_CH*DATA_W-1:0]   tap_data;
  logic [N_CH*DATA_W-1:0]   tap_weight;
  logic [N_CH*DATA_W-1:0]   bias;
  logic [N_CH*DATA_W-1:0]   res_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_CH*DATA_W-1:0]   out_data;

  modport master (
    output tap_valid, tap_data, tap_weight, bias, res_data, out_ready,
    input  tap_ready, out_valid, out_data
  );

  modport slave (
    input  tap_valid, tap_data, tap_weight, bias, res_data, out_ready,
    output tap_ready, out_valid, out_data
  );
endinterface

// File: rtl/fixed_sat_relu6.sv
// Combinational saturate to DATA_W, optional ReLU6 clamp, and saturation indicator.
module fixed_sat_relu6
  import shufflenet_pkg::*;
#(
  parameter int unsigned IN_W   = 42,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8
) (
  input  logic signed [IN_W-1:0]   val,
  input  logic                     relu6,
  output logic signed [DATA_W-1:0] res,
  output logic                     sat_hit
);

  localparam logic signed [63:0] SixQ = six_of(FRAC_W);

  logic signed [63:0] wide;
  logic signed [63:0] clamped;
  logic signed [63:0] capped;

  always_comb begin
    wide    = 64'(val);
    clamped = sat(wide, DATA_W);
    sat_hit = (clamped != wide);
    capped  = clamped;
    if (relu6) begin
      if (clamped < 64'sd0) begin
        capped = 64'sd0;
      end else if (clamped > SixQ) begin
        capped = SixQ;
      end
    end
    res = capped[DATA_W-1:0];
  end

endmodule

// File: rtl/shufflenet_layer_pipe.sv
// N-channel ShuffleNet layer datapath: depthwise MAC / max-pool / add / pass per window,
// then round, bias, saturate, ReLU6 and channel shuffle into a held output register.
module shufflenet_layer_pipe
  import shufflenet_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned GROUPS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    abort,
  input  logic [1:0]              cfg_mode,
  input  logic                    cfg_relu6,
  input  logic                    cfg_shuffle,
  input  logic                    clr_sat,
  output logic                    busy,
  output logic                    sat_flag,
  shufflenet_layer_pipe_if.slave  strm
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned PW     = ACC_W + 2;
  localparam logic signed [PW-1:0] Half = {{(PW - 1){1'b0}}, 1'b1} << (FRAC_W - 1);

  state_e                     state_q, state_d;
  mode_e                      mode_q, mode_d;
  logic                       relu6_q, relu6_d;
  logic                       shuffle_q, shuffle_d;
  logic [3:0]                 tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0]    acc_q [N_CH];
  logic signed [ACC_W-1:0]    acc_d [N_CH];
  logic signed [ACC_W-1:0]    acc_upd [N_CH];
  logic signed [DATA_W-1:0]   bias_q [N_CH];
  logic signed [DATA_W-1:0]   bias_d [N_CH];
  logic signed [DATA_W-1:0]   bias_in [N_CH];
  logic signed [DATA_W-1:0]   res [N_CH];
  logic signed [DATA_W-1:0]   shuf_arr [N_CH];
  logic [N_CH-1:0]            sat_hit;
  logic [N_CH*DATA_W-1:0]     post_data;
  logic [N_CH*DATA_W-1:0]     out_data_q, out_data_d;
  logic                       sat_q, sat_d;

  logic  tap_fire;
  logic  first;
  logic  last_tap;
  mode_e cur_mode;

  assign strm.tap_ready = (state_q == StIdle) || (state_q == StAcc);
  assign strm.out_valid = (state_q == StOut);
  assign strm.out_data  = out_data_q;
  assign busy           = (state_q != StIdle);
  assign sat_flag       = sat_q;

  assign tap_fire = strm.tap_valid && strm.tap_ready;
  assign first    = (state_q == StIdle);
  // Config is taken live on the first tap, from the latched copy afterwards.
  assign cur_mode = first ? mode_e'(cfg_mode) : mode_q;
  assign last_tap = first ? ((cur_mode == ModeAdd) || (cur_mode == ModePass))
                          : (tap_cnt_q == 4'd8);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam int unsigned Dst = shuffle_idx(c, N_CH, GROUPS);

    logic signed [DATA_W-1:0] td, tw, rd;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  tap_ext, prod_ext, add_ext;
    logic signed [PW-1:0]     rounded, pre;

    assign td         = strm.tap_data[c*DATA_W +: DATA_W];
    assign tw         = strm.tap_weight[c*DATA_W +: DATA_W];
    assign rd         = strm.res_data[c*DATA_W +: DATA_W];
    assign bias_in[c] = strm.bias[c*DATA_W +: DATA_W];
    assign prod       = PROD_W'(td) * PROD_W'(tw);
    assign tap_ext    = ACC_W'(td);
    assign prod_ext   = ACC_W'(prod);
    assign add_ext    = ACC_W'(td) + ACC_W'(rd);

    assign acc_upd[c] =
        (cur_mode == ModeDwconv)  ? ((first ? {ACC_W{1'b0}} : acc_q[c]) + prod_ext) :
        (cur_mode == ModeMaxpool) ? ((first || (tap_ext > acc_q[c])) ? tap_ext : acc_q[c]) :
        (cur_mode == ModeAdd)     ? add_ext : tap_ext;

    // Round half up before the bias so the bias is added at output precision.
    assign rounded = (PW'(acc_q[c]) + Half) >>> FRAC_W;
    assign pre     = (mode_q == ModeDwconv) ? (rounded + PW'(bias_q[c])) : PW'(acc_q[c]);

    fixed_sat_relu6 #(
      .IN_W   (PW),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_sat (
      .val     (pre),
      .relu6   (relu6_q),
      .res     (res[c]),
      .sat_hit (sat_hit[c])
    );

    assign shuf_arr[Dst] = res[c];
    assign post_data[c*DATA_W +: DATA_W] = shuffle_q ? shuf_arr[c] : res[c];
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    relu6_d    = relu6_q;
    shuffle_d  = shuffle_q;
    tap_cnt_d  = tap_cnt_q;
    acc_d      = acc_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    sat_d      = sat_q & ~clr_sat;

    case (state_q)
      StIdle, StAcc: begin
        if (tap_fire) begin
          if (first) begin
            mode_d    = mode_e'(cfg_mode);
            relu6_d   = cfg_relu6;
            shuffle_d = cfg_shuffle;
          end
          acc_d     = acc_upd;
          tap_cnt_d = first ? 4'd1 : tap_cnt_q + 4'd1;
          if (last_tap) begin
            bias_d  = bias_in;
            state_d = StPost;
          end else begin
            state_d = StAcc;
          end
        end
      end
      StPost: begin
        out_data_d = post_data;
        if (|sat_hit) sat_d = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        if (strm.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort drops the window like a reset but keeps the sticky saturation flag.
    if (abort) begin
      state_d    = StIdle;
      mode_d     = ModeDwconv;
      relu6_d    = 1'b0;
      shuffle_d  = 1'b0;
      tap_cnt_d  = 4'd0;
      acc_d      = '{default: '0};
      bias_d     = '{default: '0};
      out_data_d = '0;
      sat_d      = sat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= ModeDwconv;
      relu6_q    <= 1'b0;
      shuffle_q  <= 1'b0;
      tap_cnt_q  <= 4'd0;
      acc_q      <= '{default: '0};
      bias_q     <= '{default: '0};
      out_data_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      relu6_q    <= relu6_d;
      shuffle_q  <= shuffle_d;
      tap_cnt_q  <= tap_cnt_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
    end
  end

endmodule

// File: tb/tb_shufflenet_layer_pipe.sv
// Directed and randomized windows checked against a plain-arithmetic layer model.
module tb_shufflenet_layer_pipe;

  localparam int N = 4;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic       clr_sat = 1'b0;
  logic [1:0] cfg_mode = 2'b00;
  logic       cfg_relu6 = 1'b0;
  logic       cfg_shuffle = 1'b0;
  logic       busy;
  logic       sat_flag;

  shufflenet_layer_pipe_if #(.N_CH(N), .DATA_W(W)) bus ();

  shufflenet_layer_pipe #(
    .N_CH   (N),
    .DATA_W (W),
    .FRAC_W (8),
    .ACC_W  (40),
    .GROUPS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .abort       (abort),
    .cfg_mode    (cfg_mode),
    .cfg_relu6   (cfg_relu6),
    .cfg_shuffle (cfg_shuffle),
    .clr_sat     (clr_sat),
    .busy        (busy),
    .sat_flag    (sat_flag),
    .strm        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] td [9][4];
  logic signed [15:0] tw [9][4];
  logic signed [15:0] bs [4];
  logic signed [15:0] rd [4];
  logic [63:0]        exp_word;
  logic               exp_sat = 1'b0;
  logic [63:0]        got;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: whole-window arithmetic on 64-bit integers.
  task automatic compute_expected(input int mode, input bit relu, input bit shuf);
    longint acc, v;
    int oc;
    exp_word = '0;
    for (int c = 0; c < N; c++) begin
      case (mode)
        0: begin
          acc = 0;
          for (int i = 0; i < 9; i++) acc += longint'(td[i][c]) * longint'(tw[i][c]);
          v = ((acc + 128) >>> 8) + longint'(bs[c]);
        end
        1: begin
          v = td[0][c];
          for (int i = 1; i < 9; i++) if (td[i][c] > v) v = td[i][c];
        end
        2: v = longint'(td[0][c]) + longint'(rd[c]);
        default: v = td[0][c];
      endcase
      if (v > 32767) begin
        v = 32767; exp_sat = 1'b1;
      end else if (v < -32768) begin
        v = -32768; exp_sat = 1'b1;
      end
      if (relu && v < 0) v = 0;
      if (relu && v > 1536) v = 1536;
      oc = shuf ? (c % 2) * 2 + c / 2 : c;
      exp_word[oc*16 +: 16] = v[15:0];
    end
  endtask

  task automatic send_taps(input int mode, input bit relu, input bit shuf, input int n,
                           input bit scramble);
    logic [15:0] junk;
    cfg_mode    = 2'(mode);
    cfg_relu6   = relu;
    cfg_shuffle = shuf;
    for (int i = 0; i < n; i++) begin
      if (scramble && $urandom_range(0, 3) == 0) begin
        bus.tap_valid = 1'b0;
        @(negedge clk);
      end
      for (int c = 0; c < N; c++) begin
        junk = 16'($urandom);
        bus.tap_data[c*16 +: 16]   = td[i][c];
        bus.tap_weight[c*16 +: 16] = tw[i][c];
        bus.res_data[c*16 +: 16]   = rd[c];
        bus.bias[c*16 +: 16]       = (i == n - 1) ? bs[c] : junk;
      end
      bus.tap_valid = 1'b1;
      @(negedge clk);
      if (scramble) begin
        cfg_mode    = 2'($urandom);
        cfg_relu6   = 1'($urandom);
        cfg_shuffle = 1'($urandom);
      end
    end
    bus.tap_valid = 1'b0;
  endtask

  task automatic finish_window(input string tag, input int stall);
    int k;
    check({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_post_ready"}, 64'(bus.tap_ready), 64'd0);
    k = 0;
    while (!bus.out_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    got = bus.out_data;
    check({tag, "_data"}, got, exp_word);
    check({tag, "_sat"}, 64'(sat_flag), 64'(exp_sat));
    for (int s = 0; s < stall; s++) begin
      bus.tap_valid = 1'b1;
      bus.tap_data  = {$urandom, $urandom};
      @(negedge clk);
      check({tag, "_hold"}, bus.out_data, got);
      check({tag, "_hold_rdy"}, 64'(bus.tap_ready), 64'd0);
    end
    bus.tap_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, 64'({busy, bus.out_valid}), 64'd0);
  endtask

  task automatic fill_const(input logic signed [15:0] t, input logic signed [15:0] w);
    for (int i = 0; i < 9; i++) for (int c = 0; c < N; c++) begin
      td[i][c] = t;
      tw[i][c] = w;
    end
    for (int c = 0; c < N; c++) begin
      bs[c] = 16'sd0;
      rd[c] = 16'sd0;
    end
  endtask

  task automatic fill_random();
    logic signed [15:0] r;
    for (int i = 0; i < 9; i++) for (int c = 0; c < N; c++) begin
      r = 16'($urandom);
      td[i][c] = r >>> $urandom_range(0, 8);
      r = 16'($urandom);
      tw[i][c] = r >>> $urandom_range(0, 8);
    end
    for (int c = 0; c < N; c++) begin
      r = 16'($urandom);
      bs[c] = r >>> $urandom_range(0, 6);
      r = 16'($urandom);
      rd[c] = r >>> $urandom_range(0, 2);
    end
  endtask

  task automatic run(input string tag, input int mode, input bit relu, input bit shuf,
                     input int stall, input bit scramble);
    compute_expected(mode, relu, shuf);
    send_taps(mode, relu, shuf, (mode < 2) ? 9 : 1, scramble);
    finish_window(tag, stall);
  endtask

  initial begin
    bus.tap_valid  = 1'b0;
    bus.out_ready  = 1'b0;
    bus.tap_data   = '0;
    bus.tap_weight = '0;
    bus.bias       = '0;
    bus.res_data   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ready", 64'(bus.tap_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    check("rst_data", bus.out_data, 64'd0);

    fill_const(16'sh0100, 16'sh0100);
    run("dw_relu6", 0, 1'b1, 1'b0, 0, 1'b0);
    check("dw_relu6_k", got, 64'h0600_0600_0600_0600);
    run("dw_plain", 0, 1'b0, 1'b0, 1, 1'b0);
    check("dw_plain_k", got, 64'h0900_0900_0900_0900);

    fill_random();
    for (int c = 0; c < N; c++) bs[c] = 16'sd0;
    td[0][0] = -16'sd3; td[1][0] = 16'sd5; td[2][0] = 16'sh0280; td[3][0] = 16'sd1;
    td[4][0] = 16'sd2;  td[5][0] = 16'sd3; td[6][0] = 16'sd4;     td[7][0] = 16'sd0;
    td[8][0] = -16'sd1;
    run("maxpool", 1, 1'b0, 1'b0, 0, 1'b1);
    check("maxpool_ch0", 64'(got[15:0]), 64'h0280);

    for (int i = 0; i < 9; i++) for (int c = 0; c < N; c++)
      td[i][c] = -16'($urandom_range(1, 3000));
    run("max_neg_relu", 1, 1'b1, 1'b0, 0, 1'b0);
    check("max_neg_relu_k", got, 64'd0);

    fill_const(16'sh7F00, 16'sh0000);
    for (int c = 0; c < N; c++) rd[c] = 16'sh7F00;
    run("add_sat", 2, 1'b0, 1'b0, 0, 1'b0);
    check("add_sat_k", got, 64'h7FFF_7FFF_7FFF_7FFF);
    check("add_sat_flag", 64'(sat_flag), 64'd1);
    clr_sat = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0;
    exp_sat = 1'b0;
    check("clr_sat", 64'(sat_flag), 64'd0);

    fill_const(16'sh0000, 16'sh0000);
    td[0][0] = 16'sh0100; td[0][1] = 16'sh0200; td[0][2] = 16'sh0300; td[0][3] = 16'sh0400;
    run("pass_shuf", 3, 1'b0, 1'b1, 5, 1'b0);
    check("pass_shuf_k", got, 64'h0400_0200_0300_0100);

    // Set the sticky flag, then abort a DWCONV window after four taps.
    fill_const(16'sh7F00, 16'sh0000);
    for (int c = 0; c < N; c++) rd[c] = 16'sh7F00;
    run("add_sat2", 2, 1'b0, 1'b0, 0, 1'b0);
    fill_random();
    send_taps(0, 1'b0, 1'b0, 4, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sat_hold", 64'(sat_flag), 64'd1);
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) check("abort_no_valid", 64'(bus.out_valid), 64'd0);
    end
    fill_const(16'sh0100, 16'sh0100);
    run("after_abort", 0, 1'b0, 1'b0, 0, 1'b0);
    check("after_abort_k", got, 64'h0900_0900_0900_0900);

    fill_random();
    send_taps(0, 1'b0, 1'b0, 4, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_sat = 1'b0;
    check("rst2_busy", 64'(busy), 64'd0);
    check("rst2_sat", 64'(sat_flag), 64'd0);
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) check("rst2_no_valid", 64'(bus.out_valid), 64'd0);
    end
    fill_const(16'sh0100, 16'sh0100);
    run("after_rst", 0, 1'b1, 1'b0, 0, 1'b0);
    check("after_rst_k", got, 64'h0600_0600_0600_0600);

    for (int t = 0; t < 40; t++) begin
      fill_random();
      if ($urandom_range(0, 4) == 0) begin
        clr_sat = 1'b1;
        @(negedge clk);
        clr_sat = 1'b0;
        exp_sat = 1'b0;
      end
      run($sformatf("rand%0d", t), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 3)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
